// File: rtl/dp_stall_rx.sv
// Receive end of the stall-based dp pipeline: buffers upstream beats in a
// DEPTH-entry FIFO, back-pressures by stall, and hands out valid/ready beats.
module dp_stall_rx #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         vld_i,
    input  logic [W-1:0]                 dat_i,
    output logic                         stall_o,
    output logic                         vld_o,
    output logic [W-1:0]                 dat_o,
    input  logic                         rdy_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o,
    output logic [CNT_W-1:0]             stall_cnt_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] stall_cnt;
    logic             push;
    logic             pop;

    // Stall depends on registered occupancy only, so rdy_i never reaches stall_o.
    assign stall_o     = (occ == OCC_W'(DEPTH));
    assign vld_o       = (occ != '0);
    assign dat_o       = mem[rptr];
    assign occ_o       = occ;
    assign stall_cnt_o = stall_cnt;

    // While stalled the upstream is replaying the same beat, so vld_i is ignored.
    assign push = vld_i & ~stall_o & ~flush_i;
    assign pop  = vld_o & rdy_i & ~flush_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage has no reset; occ gates vld_o, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dat_i;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rptr      <= '0;
            wptr      <= '0;
            occ       <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                rptr <= '0;
                wptr <= '0;
                occ  <= '0;
            end else begin
                if (push) wptr <= ptr_inc(wptr);
                if (pop)  rptr <= ptr_inc(rptr);
                if (push && !pop)      occ <= occ + 1'b1;
                else if (pop && !push) occ <= occ - 1'b1;
            end
            if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
        pop |-> (occ != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
        push |-> (occ != OCC_W'(DEPTH)));
    a_stalled_data_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (stall_o && vld_i) |=> (dat_i == $past(dat_i)));
`endif

endmodule

// File: tb/tb_dp_stall_rx.sv
// Directed bench for dp_stall_rx: W=8, DEPTH=4, plus a CNT_W=2 instance for
// counter saturation; expected values are hand-computed or from a tiny model.
module tb_dp_stall_rx;

    logic        clk = 1'b0;
    logic        arst_n;

    logic        vld, rdy, flush;
    logic [7:0]  dat;
    logic        stall, vo;
    logic [7:0]  dout;
    logic [2:0]  occ;
    logic [15:0] cnt;

    logic        s_vld, s_rdy;
    logic [7:0]  s_dat;
    logic        s_stall, s_vo;
    logic [7:0]  s_dout;
    logic [2:0]  s_occ;
    logic [1:0]  s_cnt;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_stall_rx #(.W(8), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .arst_n(arst_n), .vld_i(vld), .dat_i(dat), .stall_o(stall),
        .vld_o(vo), .dat_o(dout), .rdy_i(rdy), .flush_i(flush), .occ_o(occ),
        .stall_cnt_o(cnt)
    );

    dp_stall_rx #(.W(8), .DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .arst_n(arst_n), .vld_i(s_vld), .dat_i(s_dat), .stall_o(s_stall),
        .vld_o(s_vo), .dat_o(s_dout), .rdy_i(s_rdy), .flush_i(1'b0), .occ_o(s_occ),
        .stall_cnt_o(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   idx, exp_idx, occ_m, cnt_exp;
    bit   push_m, pop_m, r;
    int   sat_exp [6] = '{1, 2, 3, 3, 3, 3};
    logic [7:0] a_seq [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    initial begin
        arst_n = 1'b0;
        vld = 1'b0; dat = 8'h00; rdy = 1'b0; flush = 1'b0;
        s_vld = 1'b0; s_dat = 8'h5A; s_rdy = 1'b0;

        // Reset state
        #12;
        check("rst_occ",   32'(occ),   0);
        check("rst_vld",   32'(vo),    0);
        check("rst_stall", 32'(stall), 0);
        check("rst_cnt",   32'(cnt),   0);
        #5 arst_n = 1'b1;

        // Streaming 0x11,0x22,0x33 with rdy high: one beat in flight at a time
        rdy = 1'b1; vld = 1'b1; dat = 8'h11;
        check("t1_vld_before", 32'(vo), 0);
        tick();
        check("t1_vld_11", 32'(vo), 1);
        check("t1_dat_11", 32'(dout), 32'h11);
        check("t1_occ_11", 32'(occ), 1);
        dat = 8'h22;
        tick();
        check("t1_dat_22", 32'(dout), 32'h22);
        check("t1_occ_22", 32'(occ), 1);
        dat = 8'h33;
        tick();
        check("t1_dat_33", 32'(dout), 32'h33);
        check("t1_occ_33", 32'(occ), 1);
        check("t1_stall", 32'(stall), 0);
        vld = 1'b0;
        tick();
        check("t1_empty", 32'(occ), 0);
        check("t1_vld_end", 32'(vo), 0);

        // Fill to full with rdy low
        rdy = 1'b0; vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat = 8'hA0 + 8'(i);
            check("t2_no_stall_yet", 32'(stall), 0);
            tick();
        end
        check("t2_full_occ", 32'(occ), 4);
        check("t2_full_stall", 32'(stall), 1);
        check("t2_cnt0", 32'(cnt), 0);

        // Upstream holds 0xA4 for 3 stalled cycles; it must not be taken
        dat = 8'hA4;
        tick(); tick(); tick();
        check("t2_hold_occ", 32'(occ), 4);
        check("t2_hold_cnt", 32'(cnt), 3);
        check("t2_head_a0", 32'(dout), 32'hA0);

        // One-cycle rdy pops 0xA0; stall drops next cycle, then 0xA4 enters
        rdy = 1'b1;
        tick();
        check("t3_pop_occ", 32'(occ), 3);
        check("t3_stall_low", 32'(stall), 0);
        check("t3_cnt", 32'(cnt), 4);
        rdy = 1'b0;
        tick();
        check("t3_a4_in_occ", 32'(occ), 4);
        check("t3_a4_in_stall", 32'(stall), 1);
        vld = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'(dout), 32'(a_seq[i]));
            tick();
        end
        check("t3_drained", 32'(occ), 0);
        check("t3_cnt_end", 32'(cnt), 5);

        // Ten beats with rdy toggling 1,0,1,0: pointers wrap, stalls occur
        idx = 0; exp_idx = 0; occ_m = 0; cnt_exp = 5; r = 1'b1;
        for (int cyc = 0; cyc < 100 && !(idx == 10 && occ_m == 0); cyc++) begin
            check("t4_occ",   32'(occ),   32'(occ_m));
            check("t4_stall", 32'(stall), 32'(occ_m == 4));
            check("t4_vld",   32'(vo),    32'(occ_m != 0));
            if (occ_m != 0) check("t4_dat", 32'(dout), 32'(exp_idx));
            vld = (idx < 10);
            dat = 8'(idx);
            rdy = r;
            push_m = vld && (occ_m != 4);
            pop_m  = (occ_m != 0) && rdy;
            if (occ_m == 4) cnt_exp++;
            tick();
            if (push_m) idx++;
            if (pop_m)  exp_idx++;
            occ_m = occ_m + int'(push_m) - int'(pop_m);
            r = ~r;
        end
        check("t4_all_out", 32'(exp_idx), 10);
        check("t4_vld_end", 32'(vo), 0);
        check("t4_cnt", 32'(cnt), 32'(cnt_exp));

        // Flush at occ=3 with a concurrent push and pop attempt
        vld = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dat = 8'hB0 + 8'(i);
            tick();
        end
        check("t5_occ3", 32'(occ), 3);
        flush = 1'b1; rdy = 1'b1; dat = 8'hB3;
        tick();
        check("t5_flush_occ", 32'(occ), 0);
        check("t5_flush_vld", 32'(vo), 0);
        check("t5_flush_stall", 32'(stall), 0);
        check("t5_flush_cnt", 32'(cnt), 32'(cnt_exp));
        flush = 1'b0; vld = 1'b0; rdy = 1'b0;
        tick();
        check("t5_no_ghost_push", 32'(occ), 0);
        vld = 1'b1; dat = 8'hC0;
        tick();
        check("t5_after_occ", 32'(occ), 1);
        check("t5_after_dat", 32'(dout), 32'hC0);
        vld = 1'b0; rdy = 1'b1;
        tick();
        check("t5_after_empty", 32'(occ), 0);

        // 2-bit stall counter saturates; main DUT gets two beats in flight
        rdy = 1'b0;
        s_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld = (i < 2);
            dat = 8'hD0 + 8'(i);
            tick();
        end
        vld = 1'b0;
        check("t6_sat_full", 32'(s_occ), 4);
        check("t6_sat_stall", 32'(s_stall), 1);
        check("t6_sat_cnt0", 32'(s_cnt), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_sat_cnt", 32'(s_cnt), 32'(sat_exp[i]));
        end
        check("t6_main_inflight", 32'(occ), 2);

        // Asynchronous reset mid-stream, away from any clock edge
        #2 arst_n = 1'b0;
        #1;
        check("t7_occ",     32'(occ),     0);
        check("t7_vld",     32'(vo),      0);
        check("t7_stall",   32'(stall),   0);
        check("t7_cnt",     32'(cnt),     0);
        check("t7_s_occ",   32'(s_occ),   0);
        check("t7_s_vld",   32'(s_vo),    0);
        check("t7_s_stall", 32'(s_stall), 0);
        check("t7_s_cnt",   32'(s_cnt),   0);
        s_vld = 1'b0;
        #4 arst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/dp_stall_rx.md
Name: dp_stall_rx

Overview:
- Receiving end of the stall-based `dp` datapath pipeline.
- Consumes vld/dat from the last pipeline stage and buffers it in a DEPTH-entry FIFO.
- Drives the upstream pipeline's stall input.
- Presents a valid/ready interface downstream, converting global-stall flow control into per-transfer handshaking without losing or duplicating beats.

Parameters:
- W, 32, data width; must match the upstream pipeline W.
- DEPTH, 4, FIFO entries; legal range 2..256, power of two not required.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock
- arst_n  input  1  asynchronous active-low reset
- vld_i  input  1  valid from the upstream pipeline output; held high while stalled
- dat_i  input  W  data from the upstream pipeline output; held stable while stalled
- stall_o  output  1  stall to the upstream pipeline
- vld_o  output  1  downstream valid
- dat_o  output  W  downstream data (head of FIFO)
- rdy_i  input  1  downstream ready
- flush_i  input  1  synchronous flush; discards all buffered entries
- occ_o  output  $clog2(DEPTH+1)  current FIFO occupancy
- stall_cnt_o  output  CNT_W  saturating count of cycles with stall_o=1

Behaviour:
- Reset (arst_n=0, asynchronous):
  - Read pointer, write pointer and occ are 0; stall_o=0, vld_o=0, occ_o=0, stall_cnt_o=0.
  - Storage array is not reset.
  - dat_o is don't-care while vld_o=0.
- Push = vld_i & ~stall_o & ~flush_i.
  - vld_i is ignored while stall_o=1, because the upstream holds the same beat during a stall; sampling it again would duplicate the beat.
- Pop = vld_o & rdy_i & ~flush_i.
- stall_o = (occ == DEPTH), decoded from registered state only, with no combinational path from rdy_i or vld_i.
  - A pop in a full cycle does not deassert stall_o until the next cycle. This one-bubble cost is accepted.
  - Because stall_o=0 implies occ<DEPTH, a push can never overflow.
- Latency: a beat pushed in cycle t appears on dat_o with vld_o=1 in cycle t+1 at the earliest. There is no same-cycle bypass.
- vld_o = (occ != 0); dat_o = mem[rptr].
- Pointer updates:
  - Pointers wrap from DEPTH-1 to 0; explicit compare, not a modulo power of two.
  - Simultaneous push and pop: both pointers advance and occ is unchanged. Legal at occ=0 only if vld_o=0, so a pop cannot occur there.
  - occ updates as occ + push - pop.
- Ordering: strict FIFO; beats leave in arrival order.
- flush_i=1:
  - Next cycle: rptr=wptr=0, occ=0, vld_o=0, stall_o=0.
  - Any push or pop in the flush cycle is discarded or not counted.
  - stall_cnt_o is not cleared.
- stall_cnt_o:
  - Increments by 1 in each cycle stall_o=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset mid-operation: all state returns to reset values immediately; in-flight beats are lost.
- Upstream built with validity tracking disabled presents vld_i=1 constantly. The block then fills to DEPTH and throttles by stall; it remains correct.
- Assertions:
  - No pop when occ==0.
  - No push when occ==DEPTH.
  - While stall_o=1 and vld_i=1, dat_i is stable.

Test Plan:
- W=8, DEPTH=4; after reset, push 0x11,0x22,0x33 on consecutive cycles with rdy_i=1 -> vld_o rises one cycle after the first push; dat_o shows 0x11,0x22,0x33 in consecutive cycles; occ_o never exceeds 1; stall_o stays 0.
- rdy_i=0, push 0xA0..0xA3 -> occ_o=4 and stall_o=1 in the cycle after the 4th push. Hold vld_i=1, dat_i=0xA4 for 3 cycles -> occ stays 4; 0xA4 is not pushed; stall_cnt_o=3.
- From the full state, raise rdy_i for one cycle -> 0xA0 popped; stall_o=0 the following cycle; 0xA4 pushed that cycle; output order is 0xA1,0xA2,0xA3,0xA4.
- Wrap-around: stream 10 beats 0x00..0x09 with rdy_i toggling 1,0,1,0 -> all 10 beats appear in order; no loss or duplication; pointers wrap at least twice.
- occ=3, assert flush_i with vld_i=1 and rdy_i=1 -> next cycle occ_o=0, vld_o=0, stall_o=0; neither the flush-cycle push nor the pop takes effect; stall_cnt_o unchanged.
- CNT_W=2, hold full with rdy_i=0 for 6 cycles -> stall_cnt_o reads 1,2,3,3,3,3. Assert arst_n=0 mid-stream -> all outputs zero asynchronously.
